// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control-field encodings and the decoded control bundle for the RV32I decode stage
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [3:0] MEM_NONE = 4'b0000;
  localparam logic [3:0] MEM_B    = 4'b0001;
  localparam logic [3:0] MEM_H    = 4'b0010;
  localparam logic [3:0] MEM_W    = 4'b1000;
  localparam logic [3:0] MEM_BU   = 4'b1001;
  localparam logic [3:0] MEM_HU   = 4'b1010;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_UIMM = 2'b11} result_src_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [2:0] {
    IMM_NONE = 3'b000, IMM_I = 3'b001, IMM_S = 3'b010, IMM_B = 3'b011,
    IMM_U = 3'b100, IMM_J = 3'b101, IMM_SHAMT = 3'b110
  } imm_src_e;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic        alu_src;
    logic        imm_ui;
    logic        mul_div;
    logic        illegal;
    result_src_e result_src;
    logic [3:0]  mem_write;
    logic [3:0]  mem_read;
    alu_op_e     alu_op;
    imm_src_e    imm_src;
  } ctrl_t;
  function automatic logic [3:0] mem_read_enc(input logic [2:0] f3);
    return f3 == 3'b000 ? MEM_B  :
           f3 == 3'b001 ? MEM_H  :
           f3 == 3'b010 ? MEM_W  :
           f3 == 3'b100 ? MEM_BU :
           f3 == 3'b101 ? MEM_HU : MEM_NONE;
  endfunction
  function automatic logic [3:0] mem_write_enc(input logic [2:0] f3);
    return f3 == 3'b000 ? MEM_B :
           f3 == 3'b001 ? MEM_H :
           f3 == 3'b010 ? MEM_W : MEM_NONE;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I(+M) instruction decode into the control bundle with illegal detection
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_MEXT        = 1'b1,
  parameter bit EN_SHAMT_CHECK = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  always_comb begin
    ctrl_o = '0;
    case (op)
      OP_R: begin
        ctrl_o.rd = instr_i[11:7];
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.rs2 = instr_i[24:20];
        ctrl_o.funct3 = f3;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op = ALU_FUNCT;
        ctrl_o.mul_div = EN_MEXT && f7 == F7_MULDIV;
        ctrl_o.illegal = !EN_MEXT && f7 == F7_MULDIV;
      end
      OP_IMM: begin
        ctrl_o.rd = instr_i[11:7];
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.funct3 = f3;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.alu_op = ALU_FUNCT;
        ctrl_o.imm_src = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
        ctrl_o.illegal = EN_SHAMT_CHECK && ((f3 == 3'b001 && f7 != F7_ZERO) ||
                         (f3 == 3'b101 && f7 != F7_ZERO && f7 != F7_ALT));
      end
      OP_LOAD: begin
        ctrl_o.rd = instr_i[11:7];
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.funct3 = f3;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.imm_src = IMM_I;
        ctrl_o.mem_read = mem_read_enc(f3);
        ctrl_o.illegal = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      OP_STORE: begin
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.rs2 = instr_i[24:20];
        ctrl_o.funct3 = f3;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.imm_src = IMM_S;
        ctrl_o.mem_write = mem_write_enc(f3);
        ctrl_o.illegal = f3 >= 3'b011;
      end
      OP_BRANCH: begin
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.rs2 = instr_i[24:20];
        ctrl_o.funct3 = f3;
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_BR;
        ctrl_o.imm_src = IMM_B;
      end
      OP_JAL: begin
        ctrl_o.rd = instr_i[11:7];
        ctrl_o.reg_write = 1'b1;
        ctrl_o.jump = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.imm_src = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.rd = instr_i[11:7];
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.funct3 = f3;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.jalr = 1'b1;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.imm_src = IMM_I;
        ctrl_o.illegal = f3 != 3'b000;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_o.rd = instr_i[11:7];
        ctrl_o.reg_write = 1'b1;
        ctrl_o.result_src = RES_UIMM;
        ctrl_o.imm_src = IMM_U;
        ctrl_o.imm_ui = op == OP_LUI;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    // illegal entries still travel downstream for the trap, but must not touch architectural state
    if (ctrl_o.illegal) begin
      ctrl_o.reg_write = 1'b0;
      ctrl_o.mem_write = MEM_NONE;
      ctrl_o.mem_read = MEM_NONE;
      ctrl_o.jump = 1'b0;
      ctrl_o.jalr = 1'b0;
      ctrl_o.branch = 1'b0;
    end
  end
endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: decode stage with a 2-entry skid buffer between fetch and execute
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int PC_W           = 32,
  parameter bit EN_MEXT        = 1'b1,
  parameter bit EN_SHAMT_CHECK = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic            RegWrite_o,
  output logic            Jump_o,
  output logic            Jalr_o,
  output logic            Branch_o,
  output logic            ALUsrc_o,
  output logic            ImmUI_o,
  output logic            MulDiv_o,
  output logic            Illegal_o,
  output logic [1:0]      ResultSrc_o,
  output logic [3:0]      MemWrite_o,
  output logic [3:0]      MemRead_o,
  output logic [1:0]      ALUop_o,
  output logic [2:0]      ImmSrc_o
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    ctrl_t           ctrl;
  } entry_t;
  state_e state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, new_e, out_e;
  ctrl_t  dec;
  logic   accept, pop;
  ctrl_decode #(.EN_MEXT(EN_MEXT), .EN_SHAMT_CHECK(EN_SHAMT_CHECK)) u_dec (
    .instr_i(instr_i),
    .ctrl_o (dec)
  );
  assign new_e       = {pc_i, dec};
  assign in_ready_o  = state_q != S_FULL;
  assign out_valid_o = state_q != S_EMPTY;
  assign accept      = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush_i) state_d = S_EMPTY;
    else begin
      case (state_q)
        S_EMPTY: begin
          head_d = accept ? new_e : head_q;
          state_d = accept ? S_ONE : S_EMPTY;
        end
        S_ONE: begin
          head_d = (accept && pop) ? new_e : head_q;
          skid_d = (accept && !pop) ? new_e : skid_q;
          state_d = (accept && !pop) ? S_FULL : (pop && !accept) ? S_EMPTY : S_ONE;
        end
        S_FULL: begin
          head_d = pop ? skid_q : head_q;
          state_d = pop ? S_ONE : S_FULL;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
  // stale head contents never leak out while the stage is empty
  assign out_e       = out_valid_o ? head_q : '0;
  assign pc_o        = out_e.pc;
  assign rd_o        = out_e.ctrl.rd;
  assign rs1_o       = out_e.ctrl.rs1;
  assign rs2_o       = out_e.ctrl.rs2;
  assign funct3_o    = out_e.ctrl.funct3;
  assign RegWrite_o  = out_e.ctrl.reg_write;
  assign Jump_o      = out_e.ctrl.jump;
  assign Jalr_o      = out_e.ctrl.jalr;
  assign Branch_o    = out_e.ctrl.branch;
  assign ALUsrc_o    = out_e.ctrl.alu_src;
  assign ImmUI_o     = out_e.ctrl.imm_ui;
  assign MulDiv_o    = out_e.ctrl.mul_div;
  assign Illegal_o   = out_e.ctrl.illegal;
  assign ResultSrc_o = out_e.ctrl.result_src;
  assign MemWrite_o  = out_e.ctrl.mem_write;
  assign MemRead_o   = out_e.ctrl.mem_read;
  assign ALUop_o     = out_e.ctrl.alu_op;
  assign ImmSrc_o    = out_e.ctrl.imm_src;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: directed and random checks of two stage configurations against a queue-based reference
module tb_ctrl_decode_stage;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc_in = '0;
  logic in_ready[2], out_valid[2], rw[2], jmp[2], jr[2], br[2], asrc[2], ui[2], md[2], ill[2];
  logic [31:0] pc_o[2];
  logic [4:0] rd[2], rs1[2], rs2[2];
  logic [2:0] f3[2], isrc[2];
  logic [1:0] rsrc[2], aop[2];
  logic [3:0] mw[2], mr[2];
  logic [40:0] obs[2];
  typedef struct {logic [31:0] ins; logic [31:0] pc;} ent_t;
  ent_t q[$];
  logic [31:0] popped[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_decode_stage #(.PC_W(32), .EN_MEXT(g == 0), .EN_SHAMT_CHECK(g == 0)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[g]),
      .instr_i(instr), .pc_i(pc_in), .out_valid_o(out_valid[g]), .out_ready_i(out_ready),
      .pc_o(pc_o[g]), .rd_o(rd[g]), .rs1_o(rs1[g]), .rs2_o(rs2[g]), .funct3_o(f3[g]),
      .RegWrite_o(rw[g]), .Jump_o(jmp[g]), .Jalr_o(jr[g]), .Branch_o(br[g]), .ALUsrc_o(asrc[g]),
      .ImmUI_o(ui[g]), .MulDiv_o(md[g]), .Illegal_o(ill[g]), .ResultSrc_o(rsrc[g]),
      .MemWrite_o(mw[g]), .MemRead_o(mr[g]), .ALUop_o(aop[g]), .ImmSrc_o(isrc[g])
    );
    assign obs[g] = {rd[g], rs1[g], rs2[g], f3[g], rw[g], jmp[g], jr[g], br[g], asrc[g], ui[g],
                     md[g], ill[g], rsrc[g], mw[g], mr[g], aop[g], isrc[g]};
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference decode written straight from the instruction-class rules
  function automatic logic [40:0] ref_ctrl(input logic [31:0] i, input bit mext, input bit shchk);
    logic [6:0] op, fn7;
    logic [2:0] fn3, is;
    logic [4:0] d, s1, s2;
    logic [3:0] wr, rdm;
    logic [1:0] res, ao;
    logic [2:0] f;
    logic w, j, jl, b, a, u, m, il;
    logic [3:0] ld_tab[8];
    ld_tab = '{4'h1, 4'h2, 4'h8, 4'h0, 4'h9, 4'hA, 4'h0, 4'h0};
    op = i[6:0]; fn3 = i[14:12]; fn7 = i[31:25];
    {d, s1, s2, f, w, j, jl, b, a, u, m, il, res, wr, rdm, ao, is} = '0;
    case (op)
      7'h33: begin d = i[11:7]; s1 = i[19:15]; s2 = i[24:20]; f = fn3; w = 1; ao = 2;
        m = mext && fn7 == 7'h01; il = !mext && fn7 == 7'h01; end
      7'h13: begin d = i[11:7]; s1 = i[19:15]; f = fn3; w = 1; a = 1; ao = 2;
        is = (fn3 == 1 || fn3 == 5) ? 3'd6 : 3'd1;
        il = shchk && ((fn3 == 1 && fn7 != 0) || (fn3 == 5 && fn7 != 0 && fn7 != 7'h20)); end
      7'h03: begin d = i[11:7]; s1 = i[19:15]; f = fn3; w = 1; a = 1; res = 1; is = 1;
        rdm = ld_tab[fn3]; il = fn3 == 3 || fn3 == 6 || fn3 == 7; end
      7'h23: begin s1 = i[19:15]; s2 = i[24:20]; f = fn3; a = 1; is = 2;
        wr = fn3 == 0 ? 4'h1 : fn3 == 1 ? 4'h2 : fn3 == 2 ? 4'h8 : 4'h0; il = fn3 >= 3; end
      7'h63: begin s1 = i[19:15]; s2 = i[24:20]; f = fn3; b = 1; ao = 1; is = 3; end
      7'h6F: begin d = i[11:7]; w = 1; j = 1; res = 2; is = 5; end
      7'h67: begin d = i[11:7]; s1 = i[19:15]; f = fn3; w = 1; jl = 1; a = 1; res = 2; is = 1;
        il = fn3 != 0; end
      7'h37: begin d = i[11:7]; w = 1; res = 3; is = 4; u = 1; end
      7'h17: begin d = i[11:7]; w = 1; res = 3; is = 4; end
      default: il = 1;
    endcase
    if (il) {w, j, jl, b, wr, rdm} = '0;
    return {d, s1, s2, f, w, j, jl, b, a, u, m, il, res, wr, rdm, ao, is};
  endfunction
  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/valid%0d", tag, k), out_valid[k], q.size() > 0);
      chk($sformatf("%s/ready%0d", tag, k), in_ready[k], q.size() < 2);
      chk($sformatf("%s/pc%0d", tag, k), pc_o[k], q.size() > 0 ? q[0].pc : 32'h0);
      chk($sformatf("%s/ctrl%0d", tag, k), obs[k], q.size() > 0 ? ref_ctrl(q[0].ins, k == 0, k == 0) : 41'h0);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic ordy,
                      input logic fl, input string tag);
    logic acc, pp;
    in_valid = v; instr = ins; pc_in = pc; out_ready = ordy; flush = fl;
    acc = v && q.size() < 2;
    pp = q.size() > 0 && ordy;
    if (pp) popped.push_back(pc_o[0]);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
    @(negedge clk);
    check_all(tag);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    r = $urandom();
    r[6:0] = ops[$urandom_range(9)];
    if ($urandom_range(9) == 0) r[6:0] = 7'($urandom());
    case ($urandom_range(3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction
  initial begin
    #1 rst = 1'b1;
    #1 check_all("reset");
    @(negedge clk) rst = 1'b0;
    step(1, 32'h002081B3, 32'h0, 1, 0, "add");
    chk("add_regwrite", rw[0], 1);
    chk("add_aluop", aop[0], 2);
    chk("add_ressrc", rsrc[0], 0);
    step(1, 32'h0040A283, 32'h4, 1, 0, "lw");
    chk("lw_memread", mr[0], 4'b1000);
    chk("lw_ressrc", rsrc[0], 1);
    chk("lw_immsrc", isrc[0], 1);
    step(0, 32'h0, 32'h0, 1, 0, "drain");
    popped.delete();
    step(1, 32'h00000013, 32'h100, 0, 0, "bp1");
    step(1, 32'h00100093, 32'h104, 0, 0, "bp2");
    chk("bp_ready_low", in_ready[0], 0);
    step(1, 32'h00200113, 32'h108, 0, 0, "bp3");
    chk("bp_head_stable", pc_o[0], 32'h100);
    step(1, 32'h00200113, 32'h108, 1, 0, "bp4");
    step(1, 32'h00200113, 32'h108, 1, 0, "bp5");
    step(0, 32'h0, 32'h0, 1, 0, "bp6");
    chk("bp_count", popped.size(), 3);
    for (int k = 0; k < 3 && k < popped.size(); k++) chk($sformatf("bp_order%0d", k), popped[k], 32'h100 + 4 * k);
    step(1, 32'h0000B003, 32'h200, 0, 0, "illegal_ld");
    chk("ill_flag", ill[0], 1);
    chk("ill_memread", mr[0], 0);
    chk("ill_regwrite", rw[0], 0);
    step(1, 32'h023100B3, 32'h204, 1, 0, "mul");
    chk("mul_muldiv_en", md[0], 1);
    chk("mul_illegal_en", ill[0], 0);
    chk("mul_illegal_dis", ill[1], 1);
    chk("mul_muldiv_dis", md[1], 0);
    step(1, 32'h00000013, 32'h300, 0, 0, "fl_fill1");
    step(1, 32'h00000013, 32'h304, 0, 0, "fl_fill2");
    step(1, 32'h00000013, 32'h308, 0, 1, "flush_full");
    chk("flush_valid", out_valid[0], 0);
    chk("flush_ready", in_ready[0], 1);
    step(1, 32'h00000013, 32'h30C, 0, 0, "fl_one");
    step(1, 32'h00000013, 32'h310, 1, 1, "flush_accept");
    chk("flush_drop", out_valid[0], 0);
    step(1, 32'h00D00513, 32'h400, 0, 0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("arst_valid", out_valid[0], 0);
    chk("arst_ctrl", obs[0], 0);
    chk("arst_ready", in_ready[0], 1);
    @(negedge clk) rst = 1'b0;
    for (int n = 0; n < 400; n++)
      step($urandom_range(9) < 8, rand_instr(), $urandom(), $urandom_range(9) < 7,
           $urandom_range(19) == 0, "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, parametrised decode-and-control stage for the RV32I core: decodes a 32-bit instruction into the datapath control bundle and buffers it in a 2-entry skid buffer with valid/ready handshakes on both sides. Sits between the fetch stage and execute. Adds the M-extension decode, illegal-instruction detection, flush, and full-throughput back-pressure; don't-care fields are driven to 0, never X.

## Interface
- PC_W, 32, width of the PC carried alongside the instruction
- EN_MEXT, 1, decode MUL/DIV (opcode 0110011, funct7 0000001) and assert MulDiv_o; when 0, that encoding is illegal
- EN_SHAMT_CHECK, 1, flag SLLI/SRLI/SRAI with a bad funct7 as illegal
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- flush_i  in  1  discard all buffered entries
- in_valid_i  in  1  instruction valid from fetch
- in_ready_o  out  1  stage can accept
- instr_i  in  32  instruction word
- pc_i  in  PC_W  instruction PC
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  execute accepts head
- pc_o  out  PC_W; rd_o, rs1_o, rs2_o  out  5 each; funct3_o  out  3
- RegWrite_o, Jump_o, Jalr_o, Branch_o, ALUsrc_o, ImmUI_o, MulDiv_o, Illegal_o  out  1 each
- ResultSrc_o  out  2  00 ALU, 01 mem, 10 PC+4, 11 upper-imm
- MemWrite_o  out  4  0001 SB, 0010 SH, 1000 SW, else 0000
- MemRead_o  out  4  0001 LB, 0010 LH, 1000 LW, 1001 LBU, 1010 LHU, else 0000
- ALUop_o  out  2  00 add, 01 branch compare, 10 funct-decoded
- ImmSrc_o  out  3  001 I, 010 S, 011 B, 100 U, 101 J, 110 shamt

## Operation
- Opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI (ImmUI=1), 0010111 AUIPC (ImmUI=0).
- Field values per class as encoded above; every field not meaningful for a class is 0.
- Illegal_o=1 for: unknown opcode; load funct3 011/110/111; store funct3 ≥011; JALR funct3≠000; M-encoding with EN_MEXT=0; with EN_SHAMT_CHECK, funct3 001 with funct7≠0000000 or funct3 101 with funct7 ∉ {0000000, 0100000}.
- Illegal entries force RegWrite, MemWrite, MemRead, Jump, Jalr and Branch to 0, but are still passed downstream for trap handling.
- Buffer FSM (occupancy): EMPTY → ONE on accept; ONE → FULL on accept without pop; ONE → EMPTY on pop without accept; ONE stays ONE on accept+pop; FULL → ONE on pop.
- accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = (state≠FULL); registered and state-derived only, with no combinational path from out_ready_i.
- out_valid_o = (state≠EMPTY). All control outputs are 0 when out_valid_o=0.
- Order is strict FIFO; the skid entry promotes to head on pop.
- flush_i: state → EMPTY on the next edge. Flush beats a simultaneous accept, and the accepted instruction is dropped.
- Reset: state EMPTY, all storage and outputs 0, in_ready_o=1.

## Timing
- Latency: an instruction accepted at edge N is visible at the outputs after edge N; there is no combinational in-to-out path.
- Throughput: 1 instr/cycle while out_ready_i=1.
- Decode is combinational on instr_i before the register.
- Head outputs stay stable while out_valid_o=1 and out_ready_i=0.
- rst_i asserted mid-operation clears the stage immediately, without waiting for a clock edge.

## Structure
- Package ctrl_pkg holds:
  - opcode constants;
  - ResultSrc, ImmSrc, ALUop, MemRead and MemWrite encodings;
  - the packed ctrl bundle type.
- Sub-module ctrl_decode: purely combinational, instruction → ctrl bundle + Illegal.
- ctrl_decode_stage holds the 2-entry skid buffer and the FSM.

## Test plan
- Reset, then stream with out_ready_i=1: add x3,x1,x2 (0x002081B3), then lw x5,4(x1) (0x0040A283) → outputs appear 1 cycle later:
  - add: RegWrite=1, ALUop=10, ResultSrc=00;
  - lw: MemRead=1000, ResultSrc=01, ImmSrc=001;
  - one output per cycle.
- Back-pressure: out_ready_i=0 while three instrs are offered → in_ready_o drops after 2 accepts, head holds stable; raise out_ready_i → all three delivered in order, none lost.
- Illegal: 0x0000A003 (load funct3 010 is legal, so use funct3 011: 0x0000B003) → Illegal_o=1, MemRead=0000, RegWrite=0.
- EN_MEXT: mul x1,x2,x3 (0x023100B3) → MulDiv_o=1 with EN_MEXT=1; Illegal_o=1 with EN_MEXT=0.
- Flush with FULL buffer plus a simultaneous in_valid_i → next cycle out_valid_o=0, in_ready_o=1, flushed instr never emitted.
- Async reset asserted mid-stream between edges → out_valid_o and all controls go to 0 immediately.
